// File: rtl/vend_credit_ctrl_pkg.sv
// Shared types and widths for the coin-credit and vend controller.
package vend_credit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } vend_state_t;

    localparam int unsigned COIN_VAL_W = 8;
    localparam int unsigned BCD_W      = 8;

endpackage

// File: rtl/vend_credit_ctrl_bin2bcd.sv
// Combinational double-dabble of a binary credit value (0..99) to two BCD digits.
module vend_bin2bcd #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] bin,
    output logic [7:0]   bcd
);

    logic [7:0] acc;

    // Shift in MSB first; any bit shifted out the top would be a hundreds digit.
    always_comb begin
        acc = '0;
        for (int unsigned i = W; i > 0; i--) begin
            if (acc[3:0] > 4'd4) acc[3:0] = acc[3:0] + 4'd3;
            if (acc[7:4] > 4'd4) acc[7:4] = acc[7:4] + 4'd3;
            acc = {acc[6:0], bin[i-1]};
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin-credit accumulator and vend controller with handshaked change payout.
module vend_credit_ctrl
    import vend_credit_ctrl_pkg::*;
#(
    parameter int unsigned                   N_COINS    = 3,
    parameter logic [COIN_VAL_W*N_COINS-1:0] COIN_VALS  = {8'd5, 8'd2, 8'd1},
    parameter int unsigned                   PRICE      = 10,
    parameter int unsigned                   CW         = 8,
    parameter int unsigned                   MAX_CREDIT = 99,
    parameter int unsigned                   CHG_UNIT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_COINS-1:0] coin_in,
    input  logic               vend_req,
    input  logic               refund_req,
    input  logic               chg_ready,
    output logic               chg_valid,
    output logic               vend_pulse,
    output logic               coin_reject,
    output logic               short_pulse,
    output logic               busy,
    output logic [CW-1:0]      credit,
    output logic [BCD_W-1:0]   credit_bcd
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] UNIT_C  = CW'(CHG_UNIT);

    vend_state_t state_q, state_d;

    logic [CW-1:0]         credit_q, credit_d;
    logic [N_COINS-1:0]    coin_prev_q;
    logic [N_COINS-1:0]    coin_edge;
    logic [N_COINS-1:0]    edge_low;
    logic [COIN_VAL_W-1:0] sel_val;
    logic [CW:0]           coin_sum;
    logic                  coin_any;
    logic                  coin_extra;
    logic                  coin_ok;
    logic                  reject_d;
    logic                  short_d;
    logic [BCD_W-1:0]      bcd_d;

    assign coin_edge  = coin_in & ~coin_prev_q;
    assign edge_low   = coin_edge & (~coin_edge + N_COINS'(1));
    assign coin_any   = |coin_edge;
    assign coin_extra = |(coin_edge & ~edge_low);

    always_comb begin
        sel_val = '0;
        for (int unsigned i = 0; i < N_COINS; i++) begin
            if (edge_low[i]) sel_val = COIN_VALS[COIN_VAL_W*i +: COIN_VAL_W];
        end
    end

    assign coin_sum = {1'b0, credit_q} + (CW+1)'(sel_val);
    assign coin_ok  = coin_any && (coin_sum <= MAX_C);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        short_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_ok) credit_d = coin_sum[CW-1:0];
                reject_d = (coin_any && !coin_ok) || coin_extra;
                // vend_req blocks refund outright, even when it only produces a short pulse
                if (vend_req) begin
                    if (credit_q >= PRICE_C) state_d = ST_VEND;
                    else                     short_d = 1'b1;
                end else if (refund_req && (credit_q != '0)) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_VEND: begin
                reject_d = coin_any;
                if (credit_q > PRICE_C) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = ST_CHANGE;
                end else begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                reject_d = coin_any;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (chg_valid && chg_ready) begin
                    if (credit_q <= UNIT_C) begin
                        credit_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        credit_d = credit_q - UNIT_C;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    vend_bin2bcd #(
        .W (CW)
    ) u_bin2bcd (
        .bin (credit_q),
        .bcd (bcd_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            coin_prev_q <= '1;
            chg_valid   <= 1'b0;
            vend_pulse  <= 1'b0;
            coin_reject <= 1'b0;
            short_pulse <= 1'b0;
            busy        <= 1'b0;
            credit_bcd  <= '0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            coin_prev_q <= coin_in;
            chg_valid   <= (state_d == ST_CHANGE);
            vend_pulse  <= (state_d == ST_VEND);
            coin_reject <= reject_d;
            short_pulse <= short_d;
            busy        <= (state_d != ST_IDLE);
            credit_bcd  <= bcd_d;
        end
    end

    assign credit = credit_q;

endmodule
